seg7_scan_decoder: RTL and testbench

Reverse path of the BCD-to-7-segment encoding. The block monitors a time-multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode enables) and debounces each digit dwell. It decodes each segment pattern back to a BCD nibble and assembles a complete multi-digit frame. It is used on-chip as a self-check and readback monitor for the display path, for example to verify displayed AES status digits in test.

---
 rtl/seg7_scan_decoder.sv | 197 +++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder
//
// Watches a time-multiplexed, active-low 7-segment display bus and rebuilds
// the multi-digit value it shows. Each digit dwell has to be stable for
// STABLE_CYCLES samples before it is accepted. The accepted pattern is
// decoded back to a BCD nibble. Once every digit has been seen, the frame
// is published.
//
// Ports:
//   clk          system clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   seg_n[6:0]   segment lines, active-low, bit0=a .. bit6=g
//   an_n[N-1:0]  anode enables, active-low, an_n[i]=0 selects digit i
//   digits       last complete frame, digit i at [4i+3:4i]
//   digit_err    per-digit invalid-pattern flag of the last frame
//   frame_valid  one-cycle pulse when digits/digit_err update
//   stale        no digit accepted for TIMEOUT_CYCLES, cleared by next frame
// ---------------------------------------------------------------------------
module seg7_scan_decoder #(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 400000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  output logic                    stale
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {S_COLLECT, S_PUBLISH} state_t;

  // {err, nibble}: blank reads as F without error, unknown patterns as E.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1000000: r = 5'h00;
      7'b1111001: r = 5'h01;
      7'b0100100: r = 5'h02;
      7'b0110000: r = 5'h03;
      7'b0011001: r = 5'h04;
      7'b0010010: r = 5'h05;
      7'b0000010: r = 5'h06;
      7'b1111000: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0010000: r = 5'h09;
      7'b1111111: r = 5'h0F;
      default:    r = 5'h1E;
    endcase
    return r;
  endfunction

  state_t                    r_state;
  state_t                    w_state_next;
  logic [6:0]                r_seg;
  logic [NUM_DIGITS-1:0]     r_an;
  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          w_cnt_next;
  logic [NUM_DIGITS-1:0]     r_seen;
  logic [NUM_DIGITS-1:0]     w_seen_next;
  logic [4*NUM_DIGITS-1:0]   r_shadow;
  logic [NUM_DIGITS-1:0]     r_shadow_err;
  logic [TO_W-1:0]           r_to;
  logic [4*NUM_DIGITS-1:0]   r_digits;
  logic [NUM_DIGITS-1:0]     r_digit_err;
  logic                      r_fv;
  logic                      r_stale;

  logic [NUM_DIGITS-1:0]     w_act;
  logic                      w_onehot;
  logic                      w_same;
  logic                      w_accept;
  logic                      w_timeout;
  logic                      w_publish;
  logic [4:0]                w_dec;

  // ---- stage: incoming sample qualification and stability tracking ----
  assign w_act    = ~an_n;
  assign w_onehot = (w_act != '0) &&
                    ((w_act & (w_act - NUM_DIGITS'(1))) == '0);
  assign w_same   = (an_n == r_an) && (seg_n == r_seg);
  // The count reaching STABLE_CYCLES is the one-time accept; saturation
  // keeps a long dwell from accepting again.
  assign w_accept = w_onehot && w_same &&
                    (r_cnt == CNT_W'(STABLE_CYCLES - 1));
  assign w_dec    = decode_seg(seg_n);

  always_comb begin
    w_cnt_next = '0;
    if (!w_onehot)
      w_cnt_next = '0;
    else if (!w_same)
      w_cnt_next = CNT_W'(1);
    else if (r_cnt == CNT_W'(STABLE_CYCLES))
      w_cnt_next = r_cnt;
    else
      w_cnt_next = r_cnt + CNT_W'(1);
  end

  // An accept in the same cycle suppresses the timeout.
  assign w_timeout = !w_accept && (r_to == TO_W'(TIMEOUT_CYCLES - 1));

  // Publish and timeout clear the seen mask first; an accept landing in
  // that same cycle then counts toward the next frame.
  always_comb begin
    w_seen_next = (w_publish || w_timeout) ? '0 : r_seen;
    if (w_accept)
      w_seen_next = w_seen_next | w_act;
  end

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_COLLECT;
    else
      r_state <= w_state_next;
  end

  // ---- FSM: next-state ----
  always_comb begin
    w_state_next = S_COLLECT;
    if (w_accept && (&w_seen_next))
      w_state_next = S_PUBLISH;
  end

  // ---- FSM: outputs ----
  always_comb begin
    w_publish = (r_state == S_PUBLISH);
  end

  // ---- stage: sample, stability, seen mask and timeout registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg  <= '0;
      r_an   <= '0;
      r_cnt  <= '0;
      r_seen <= '0;
      r_to   <= '0;
    end else begin
      r_seg  <= seg_n;
      r_an   <= an_n;
      r_cnt  <= w_cnt_next;
      r_seen <= w_seen_next;
      if (w_accept)
        r_to <= '0;
      else if (r_to != TO_W'(TIMEOUT_CYCLES))
        r_to <= r_to + TO_W'(1);
    end
  end

  // ---- stage: per-digit shadow capture (latest accept wins) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow     <= '0;
      r_shadow_err <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_accept && w_act[i]) begin
          r_shadow[4*i +: 4] <= w_dec[3:0];
          r_shadow_err[i]    <= w_dec[4];
        end
      end
    end
  end

  // ---- stage: published frame and status ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits    <= '1;
      r_digit_err <= '0;
      r_fv        <= 1'b0;
      r_stale     <= 1'b0;
    end else begin
      r_fv <= w_publish;
      if (w_publish) begin
        r_digits    <= r_shadow;
        r_digit_err <= r_shadow_err;
        r_stale     <= 1'b0;
      end else if (w_timeout) begin
        r_stale     <= 1'b1;
      end
    end
  end

  assign digits      = r_digits;
  assign digit_err   = r_digit_err;
  assign frame_valid = r_fv;
  assign stale       = r_stale;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
module tb_seg7_scan_decoder;

  localparam int TO = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] digits;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        stale;

  seg7_scan_decoder #(
    .NUM_DIGITS(4),
    .STABLE_CYCLES(4),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .seg_n(seg_n),
    .an_n(an_n),
    .digits(digits),
    .digit_err(digit_err),
    .frame_valid(frame_valid),
    .stale(stale)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  e;
  } frame_t;

  typedef struct {
    logic [6:0]  s0;
    logic [6:0]  s1;
    logic [6:0]  s2;
    logic [6:0]  s3;
    logic [15:0] d;
    logic [3:0]  e;
  } vec_t;

  frame_t exp_q[$];
  vec_t   vecs[6];
  int     checks   = 0;
  int     failures = 0;
  int     n_frames = 0;

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_n  = an;
    seg_n = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dig(input int i, input logic [6:0] seg, input int n);
    drive(4'(~(4'b0001 << i)), seg, n);
  endtask

  task automatic expect_frame(input logic [15:0] d, input logic [3:0] e);
    frame_t f;
    f.d = d;
    f.e = e;
    exp_q.push_back(f);
  endtask

  task automatic scan_vec(input vec_t v);
    expect_frame(v.d, v.e);
    dig(0, v.s0, 8);
    dig(1, v.s1, 8);
    dig(2, v.s2, 8);
    dig(3, v.s3, 8);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_digits"}, 32'(digits), 32'h0000FFFF);
    chk({tag, "_err"},    32'(digit_err), 32'h0);
    chk({tag, "_fv"},     32'(frame_valid), 32'h0);
    chk({tag, "_stale"},  32'(stale), 32'h0);
  endtask

  initial begin
    int saved;
    vecs[0] = '{seg_of(4), seg_of(2), seg_of(0), seg_of(2), 16'h2024, 4'b0000};
    vecs[1] = '{seg_of(0), seg_of(1), seg_of(2), seg_of(3), 16'h3210, 4'b0000};
    vecs[2] = '{seg_of(4), seg_of(5), seg_of(6), seg_of(7), 16'h7654, 4'b0000};
    vecs[3] = '{seg_of(8), seg_of(9), 7'h7F, seg_of(0), 16'h0F98, 4'b0000};
    vecs[4] = '{7'h7F, seg_of(1), 7'b0000001, seg_of(5), 16'h5E1F, 4'b0100};
    vecs[5] = '{7'b1111110, seg_of(8), 7'b0111111, 7'h7F, 16'hFE8E, 4'b0101};

    rst_n = 1'b0;
    an_n  = 4'hF;
    seg_n = 7'h7F;

    // Scoreboard: every frame_valid pops one expected frame.
    fork
      forever begin
        @(negedge clk);
        if (rst_n && frame_valid) begin
          n_frames++;
          chk("frame_expected", 32'(exp_q.size() != 0), 32'h1);
          chk("stale_clear_on_frame", 32'(stale), 32'h0);
          if (exp_q.size() != 0) begin
            frame_t f;
            f = exp_q.pop_front();
            chk("frame_digits", 32'(digits), 32'(f.d));
            chk("frame_err", 32'(digit_err), 32'(f.e));
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table-driven full scans, including blank and invalid patterns.
    for (int k = 0; k < 6; k++)
      scan_vec(vecs[k]);

    // Short dwell on digit1 must not complete the frame.
    saved = n_frames;
    dig(0, seg_of(7), 8);
    dig(1, seg_of(1), 3);
    dig(2, seg_of(8), 8);
    dig(3, seg_of(9), 8);
    chk("short_dwell_no_frame", 32'(n_frames), 32'(saved));
    // Full dwell on digit1 completes it; check exact publish latency.
    expect_frame(16'h9867, 4'b0000);
    an_n  = 4'b1101;
    seg_n = seg_of(6);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("latency_fv_low_at_ES", 32'(frame_valid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("latency_fv_high_after_ES1", 32'(frame_valid), 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("fv_single_cycle", 32'(frame_valid), 32'h0);
    @(posedge clk);
    #1;

    // Revisit digit0 before frame completion: latest value wins.
    expect_frame(16'h3059, 4'b0000);
    dig(0, seg_of(7), 8);
    dig(1, seg_of(5), 8);
    dig(0, seg_of(9), 8);
    dig(2, seg_of(0), 8);
    dig(3, seg_of(3), 8);

    // Two anodes active, then idle into timeout; partial frame discarded.
    saved = n_frames;
    dig(0, seg_of(3), 8);
    dig(1, seg_of(3), 8);
    drive(4'b0011, seg_of(8), 10);
    drive(4'hF, 7'h7F, 170);
    chk("stale_before_timeout", 32'(stale), 32'h0);
    drive(4'hF, 7'h7F, 40);
    chk("stale_after_timeout", 32'(stale), 32'h1);
    chk("timeout_digits_kept", 32'(digits), 32'h3059);
    dig(2, seg_of(2), 8);
    dig(3, seg_of(1), 8);
    chk("timeout_cleared_seen", 32'(n_frames), 32'(saved));
    chk("stale_held_until_frame", 32'(stale), 32'h1);
    expect_frame(16'h1206, 4'b0000);
    dig(0, seg_of(6), 8);
    dig(1, seg_of(0), 8);
    chk("stale_cleared", 32'(stale), 32'h0);

    // Reset mid-scan after two digits accepted.
    saved = n_frames;
    dig(0, seg_of(9), 8);
    dig(1, seg_of(9), 8);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midscan_reset");
    an_n  = 4'hF;
    seg_n = 7'h7F;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dig(2, seg_of(3), 8);
    dig(3, seg_of(4), 8);
    chk("reset_no_carryover", 32'(n_frames), 32'(saved));
    expect_frame(16'h4321, 4'b0000);
    dig(0, seg_of(1), 8);
    dig(1, seg_of(2), 8);

    drive(4'hF, 7'h7F, 10);
    chk("all_frames_seen", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute bound on simulation time.
  initial begin
    #500000;
    $display("FAIL timeout_guard actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
